fwd_ctrl_unit: RTL
==================

// Module: fwd_ctrl_unit
// PURPOSE
// Forwarding/hazard controller for the 5-stage pipeline. Produces the 2-bit select codes that drive
// the ALU-operand forwarding muxes. Tracks destination-register state of the instructions in the
// EX, MEM and WB stages. Detects load-use hazards and inserts one bubble per hazard.
// Sits between the ID/EX pipeline-register control and the two operand forwarding muxes.
// PARAMETERS
// REG_ADDR_W  5   register-index width (32 registers; index 0 is hard-wired zero)
// CNT_W       32  width of the stall performance counter
// PORTS
// clk           in   1           pipeline clock; all state updates on rising edge
// rst           in   1           synchronous, active-high reset
// id_valid      in   1           ID stage holds a real instruction
// id_rs1        in   REG_ADDR_W  ID source register A
// id_rs2        in   REG_ADDR_W  ID source register B
// id_rd         in   REG_ADDR_W  ID destination register
// id_reg_write  in   1           ID instruction writes id_rd
// id_mem_read   in   1           ID instruction is a load
// flush         in   1           squash the ID instruction (taken branch resolved in EX)
// fwd_a         out  2           operand-A mux select for the EX instruction
// fwd_b         out  2           operand-B mux select for the EX instruction
// stall         out  1           hold PC and IF/ID this cycle; a bubble enters EX
// stall_count   out  CNT_W       saturating count of stall cycles
// BEHAVIOUR
// Select encoding (fixed by the mux):
// - 0 = register-file value
// - 1 = EX/MEM ALU result
// - 2 = MEM/WB writeback value
// - 3 = constant zero
// Internal stage records EX, MEM, WB: {valid, rs1, rs2, rd, reg_write, mem_read}.
// Only the EX record uses rs1/rs2.
// Each rising edge (rst=0):
// - WB <= MEM
// - MEM <= EX
// - EX <= ID fields if id_valid & ~flush & ~stall; otherwise EX <= bubble (valid=0, all fields 0)
// - flush and stall together: bubble
// stall (combinational from EX record + ID inputs):
// - asserted when EX.valid & EX.mem_read & EX.rd!=0 & id_valid & (id_rs1==EX.rd | id_rs2==EX.rd)
// - a stall therefore lasts exactly 1 cycle
// - on the next cycle the load is in MEM; the dependent instruction is still in ID
// - flush does not mask stall; the upstream block resolves the priority
// fwd_a (fwd_b identical using rs2), combinational from registered state only; first match wins:
// - EX.valid=0 -> 0
// - EX.rs1==0 -> 3
// - MEM.valid & MEM.reg_write & MEM.rd==EX.rs1 -> 1 (newest producer wins over WB)
// - WB.valid & WB.reg_write & WB.rd==EX.rs1 -> 2
// - otherwise 0
// - MEM.mem_read match cannot occur, because the stall prevents it.
// - A reg_write to rd 0 never forwards; the EX.rs1==0 rule covers it.
// Register-file write-then-read in the same cycle is handled by the register file, not by this block.
// stall_count:
// - +1 on every cycle with stall=1
// - saturates at all-ones and never wraps
// rst=1 (synchronous, any time, including mid-hazard):
// - all stage records become bubbles
// - stall_count <= 0
// - next cycle: fwd_a=fwd_b=0 and stall=0 (stall is 0 because EX.valid=0)
// Latency: ID->EX record takes 1 cycle. fwd_a/fwd_b are valid in the same cycle the instruction is in EX.
// TESTING
// T1 reset: rst for 2 cycles with random ID inputs -> fwd_a=fwd_b=0, stall=0, stall_count=0.
// T2 EX/MEM forward: add r3 then sub r4,r3,r5 back-to-back -> sub in EX: fwd_a=1, fwd_b=0.
// T3 MEM/WB forward + priority:
//    add r3; nop; or r6,r3,r3 -> fwd_a=fwd_b=2.
//    add r3; add r3; or r6,r3,r3 -> fwd_a=fwd_b=1.
// T4 load-use: lw r7 then add r8,r7,r1 -> stall=1 for exactly 1 cycle; stall_count 0->1;
//    add later in EX with fwd_a=2.
// T5 zero/flush/r0 cases:
//    add r9,r0,r2 -> fwd_a=3.
//    producer writing r0 -> no forward.
//    flush with valid ID -> EX bubble, next-cycle fwd=0.
// T6 saturation/reset mid-hazard:
//    CNT_W=4, 20 load-use hazards -> stall_count holds 15.
//    rst asserted during stall -> next cycle stall=0, count=0.

Source files
------------

// File: rtl/fwd_ctrl_if.sv
// Bus between the ID/EX control logic and the forwarding/hazard controller.
// The master side presents the decoded ID-stage instruction plus flush and
// receives the mux selects, the stall request and the stall counter.
interface fwd_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) ();
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a, fwd_b, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a, fwd_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Keeps a small record of the instructions in EX, MEM and WB, derives the
// ALU operand mux selects for the EX instruction and requests a one-cycle
// bubble when the ID instruction consumes the result of a load in EX.
// Select codes: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB value,
// 3 = constant zero.
module fwd_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  fwd_ctrl_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX record keeps its sources; MEM/WB only need what forwarding looks at.
  logic                  ex_valid_r;
  logic [REG_ADDR_W-1:0] ex_rs1_r;
  logic [REG_ADDR_W-1:0] ex_rs2_r;
  logic [REG_ADDR_W-1:0] ex_rd_r;
  logic                  ex_reg_write_r;
  logic                  ex_mem_read_r;
  logic                  mem_valid_r;
  logic [REG_ADDR_W-1:0] mem_rd_r;
  logic                  mem_reg_write_r;
  logic                  wb_valid_r;
  logic [REG_ADDR_W-1:0] wb_rd_r;
  logic                  wb_reg_write_r;
  logic [CNT_W-1:0]      stall_count_r;

  logic                  stall_s;
  logic [1:0]            fwd_a_s;
  logic [1:0]            fwd_b_s;

  // Priority chain for one operand: bubble, r0, newest producer (MEM), then WB.
  function automatic logic [1:0] fwd_sel(
    input logic                  ex_v,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_v,
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_v,
    input logic                  wb_rw,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    logic [1:0] sel;
    if (!ex_v) begin
      sel = 2'd0;
    end else if (src == REG_ZERO) begin
      sel = 2'd3;
    end else if (mem_v && mem_rw && (mem_rd == src)) begin
      sel = 2'd1;
    end else if (wb_v && wb_rw && (wb_rd == src)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Load-use detection against the live ID inputs, plus operand selects from stage records.
  always_comb begin
    stall_s = ex_valid_r && ex_mem_read_r && (ex_rd_r != REG_ZERO) && bus.id_valid &&
              ((bus.id_rs1 == ex_rd_r) || (bus.id_rs2 == ex_rd_r));
    fwd_a_s = fwd_sel(ex_valid_r, ex_rs1_r, mem_valid_r, mem_reg_write_r, mem_rd_r,
                      wb_valid_r, wb_reg_write_r, wb_rd_r);
    fwd_b_s = fwd_sel(ex_valid_r, ex_rs2_r, mem_valid_r, mem_reg_write_r, mem_rd_r,
                      wb_valid_r, wb_reg_write_r, wb_rd_r);
  end

  // Advance the stage records; a stalled or flushed ID slot becomes a bubble in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r      <= 1'b0;
      ex_rs1_r        <= REG_ZERO;
      ex_rs2_r        <= REG_ZERO;
      ex_rd_r         <= REG_ZERO;
      ex_reg_write_r  <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      mem_valid_r     <= 1'b0;
      mem_rd_r        <= REG_ZERO;
      mem_reg_write_r <= 1'b0;
      wb_valid_r      <= 1'b0;
      wb_rd_r         <= REG_ZERO;
      wb_reg_write_r  <= 1'b0;
    end else begin
      wb_valid_r      <= mem_valid_r;
      wb_rd_r         <= mem_rd_r;
      wb_reg_write_r  <= mem_reg_write_r;
      mem_valid_r     <= ex_valid_r;
      mem_rd_r        <= ex_rd_r;
      mem_reg_write_r <= ex_reg_write_r;
      if (bus.id_valid && !bus.flush && !stall_s) begin
        ex_valid_r     <= 1'b1;
        ex_rs1_r       <= bus.id_rs1;
        ex_rs2_r       <= bus.id_rs2;
        ex_rd_r        <= bus.id_rd;
        ex_reg_write_r <= bus.id_reg_write;
        ex_mem_read_r  <= bus.id_mem_read;
      end else begin
        ex_valid_r     <= 1'b0;
        ex_rs1_r       <= REG_ZERO;
        ex_rs2_r       <= REG_ZERO;
        ex_rd_r        <= REG_ZERO;
        ex_reg_write_r <= 1'b0;
        ex_mem_read_r  <= 1'b0;
      end
    end
  end

  // Saturating count of stall cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.fwd_a       = fwd_a_s;
  assign bus.fwd_b       = fwd_b_s;
  assign bus.stall_count = stall_count_r;

endmodule
